// File: rtl/neuron_feeder.sv
// Pairs consecutive pixels and presents them with the matching weight pair and bias
// as registered operands. Optional odd-frame zero padding: NEURON_FEEDER_ZERO_PAD_EN.
module neuron_feeder #(
    parameter int DATA_W = 20,
    parameter int NPAIRS = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_weight1,
    input  logic [DATA_W-1:0] wr_weight2,
    input  logic              bias_wr_en,
    input  logic [DATA_W-1:0] bias_wr_data,
    output logic [DATA_W-1:0] pixel1,
    output logic [DATA_W-1:0] pixel2,
    output logic [DATA_W-1:0] weight1,
    output logic [DATA_W-1:0] weight2,
    output logic [DATA_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [AW-1:0]     pair_idx,
    output logic [1:0]        fsm_state
);

    localparam int DEPTH = 1 << AW;

`ifdef NEURON_FEEDER_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] w1_mem [DEPTH];
    logic [DATA_W-1:0] w2_mem [DEPTH];
    logic [DATA_W-1:0] bias_reg;

    logic          accept, xfer, pad_now;
    logic          load_p1, load_pair, load_pad;
    logic [AW-1:0] idx_next;
    logic          wr_hit;
    logic [DATA_W-1:0] rd_w1, rd_w2, rd_bias;

    // Handshakes: a beat moves on an edge where valid and ready are both high;
    // out_valid stays high with frozen operands until out_ready, and in FULL a new
    // pixel is taken only in the same cycle the held operand set is transferred.
    assign in_ready  = (state == FULL) ? out_ready : 1'b1;
    assign out_valid = (state == FULL);
    assign accept    = in_valid && in_ready;
    assign xfer      = (state == FULL) && out_ready;
    assign pad_now   = PAD_EN && in_last;
    assign fsm_state = state;

    always_comb begin
        idx_next = pair_idx;
        if (xfer) begin
            idx_next = (out_last || pair_idx == AW'(NPAIRS - 1)) ? '0 : pair_idx + 1'b1;
        end
    end

    // A write landing on the same edge that latches the operands is forwarded.
    assign wr_hit  = wr_en && (wr_addr == idx_next);
    assign rd_w1   = wr_hit ? wr_weight1 : w1_mem[idx_next];
    assign rd_w2   = wr_hit ? wr_weight2 : w2_mem[idx_next];
    assign rd_bias = bias_wr_en ? bias_wr_data : bias_reg;

    always_comb begin
        state_next = state;
        load_p1    = 1'b0;
        load_pair  = 1'b0;
        load_pad   = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    if (pad_now) begin
                        state_next = FULL;
                        load_pad   = 1'b1;
                    end else begin
                        state_next = HALF;
                        load_p1    = 1'b1;
                    end
                end
            end
            HALF: begin
                if (accept) begin
                    state_next = FULL;
                    load_pair  = 1'b1;
                end
            end
            FULL: begin
                if (xfer) begin
                    if (accept && pad_now) begin
                        state_next = FULL;
                        load_pad   = 1'b1;
                    end else if (accept) begin
                        state_next = HALF;
                        load_p1    = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            pair_idx <= '0;
        end else begin
            state    <= state_next;
            pair_idx <= idx_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                w1_mem[i] <= '0;
                w2_mem[i] <= '0;
            end
            bias_reg <= '0;
        end else begin
            if (wr_en) begin
                w1_mem[wr_addr] <= wr_weight1;
                w2_mem[wr_addr] <= wr_weight2;
            end
            if (bias_wr_en) begin
                bias_reg <= bias_wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel1   <= '0;
            pixel2   <= '0;
            weight1  <= '0;
            weight2  <= '0;
            bias     <= '0;
            out_last <= 1'b0;
        end else begin
            if (load_p1 || load_pad) begin
                pixel1 <= in_pixel;
            end
            if (load_pair || load_pad) begin
                pixel2   <= load_pad ? '0 : in_pixel;
                weight1  <= rd_w1;
                weight2  <= rd_w2;
                bias     <= rd_bias;
                out_last <= load_pad ? 1'b1 : in_last;
            end
        end
    end

endmodule

// File: tb/tb_neuron_feeder.sv
// Self-checking bench for neuron_feeder: directed scenarios plus randomized traffic
// scored against a frame-level pairing model (NEURON_FEEDER_ZERO_PAD_EN aware).
module tb_neuron_feeder;

  localparam int DW = 20;
  localparam int NP = 8;
  localparam int AW = 3;
  localparam int EW = 5 * DW + 1 + AW;

`ifdef NEURON_FEEDER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_pixel;
  logic          in_valid, in_last, in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_weight1, wr_weight2;
  logic          bias_wr_en;
  logic [DW-1:0] bias_wr_data;
  logic [DW-1:0] pixel1, pixel2, weight1, weight2, bias;
  logic          out_valid, out_ready, out_last;
  logic [AW-1:0] pair_idx;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;
  int n_xfers = 0;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] m_w1 [NP];
  logic [DW-1:0] m_w2 [NP];
  logic [DW-1:0] m_bias;
  logic [DW-1:0] m_pix;
  logic          m_half;
  int            m_idx;
  logic          prev_hold;
  logic [EW-1:0] prev_obs;

  neuron_feeder #(.DATA_W(DW), .NPAIRS(NP), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_weight1(wr_weight1), .wr_weight2(wr_weight2),
    .bias_wr_en(bias_wr_en), .bias_wr_data(bias_wr_data),
    .pixel1(pixel1), .pixel2(pixel2), .weight1(weight1), .weight2(weight2), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .pair_idx(pair_idx), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: model pairs pixels per frame, expected sets checked at each transfer.
  always @(negedge clk) begin
    logic [EW-1:0] obs, e;
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < NP; i++) begin
        m_w1[i] = '0;
        m_w2[i] = '0;
      end
      m_bias = '0;
      m_half = 1'b0;
      m_idx = 0;
      prev_hold = 1'b0;
    end else begin
      obs = {pixel1, pixel2, weight1, weight2, bias, out_last, pair_idx};
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== prev_obs) begin
          errors++;
          $display("FAIL hold_stable act=%0b/%h exp=1/%h", out_valid, obs, prev_obs);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        n_xfers++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer act=%h exp=none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL xfer act=%h exp=%h", obs, e);
          end
        end
      end
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready act=%b exp=%b", in_ready, (!out_valid || out_ready));
      end
      if (wr_en) begin
        m_w1[wr_addr] = wr_weight1;
        m_w2[wr_addr] = wr_weight2;
      end
      if (bias_wr_en) m_bias = bias_wr_data;
      if (in_valid && in_ready) begin
        if (!m_half && PAD && in_last) begin
          exp_q.push_back({in_pixel, {DW{1'b0}}, m_w1[m_idx], m_w2[m_idx], m_bias, 1'b1, AW'(m_idx)});
          m_idx = 0;
        end else if (!m_half) begin
          m_half = 1'b1;
          m_pix = in_pixel;
        end else begin
          exp_q.push_back({m_pix, in_pixel, m_w1[m_idx], m_w2[m_idx], m_bias, in_last, AW'(m_idx)});
          m_half = 1'b0;
          m_idx = (in_last || m_idx == NP - 1) ? 0 : m_idx + 1;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_obs = obs;
    end
  end

  task automatic send_pixel(input logic [DW-1:0] p, input logic l);
    int n = 0;
    in_pixel = p;
    in_valid = 1'b1;
    in_last = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout act=in_ready0 exp=in_ready1 pixel=%0d", p);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic write_w(input logic [AW-1:0] a, input logic [DW-1:0] w1, input logic [DW-1:0] w2);
    wr_en = 1'b1;
    wr_addr = a;
    wr_weight1 = w1;
    wr_weight2 = w2;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic write_bias(input logic [DW-1:0] b);
    bias_wr_en = 1'b1;
    bias_wr_data = b;
    @(posedge clk);
    #1;
    bias_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_pixel = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_weight1 = '0; wr_weight2 = '0;
    bias_wr_en = 1'b0; bias_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs act=%b%b exp=10", in_ready, out_valid);
    end
    checks++;
    if (out_last !== 1'b0 || pair_idx !== '0) begin
      errors++;
      $display("FAIL reset_idx act=%b/%0d exp=0/0", out_last, pair_idx);
    end
    checks++;
    if ({pixel1, pixel2, weight1, weight2, bias} !== '0) begin
      errors++;
      $display("FAIL reset_operands act=%h exp=0", {pixel1, pixel2, weight1, weight2, bias});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_pair();
    write_w(3'd0, 20'd3, 20'd5);
    write_bias(20'd7);
    out_ready = 1'b0;
    send_pixel(20'd2, 1'b0);
    send_pixel(20'd4, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_valid, pixel1, pixel2, weight1, weight2, bias, out_last} !==
        {1'b1, 20'd2, 20'd4, 20'd3, 20'd5, 20'd7, 1'b1}) begin
      errors++;
      $display("FAIL single_pair act=%b %0d %0d %0d %0d %0d %b exp=1 2 4 3 5 7 1",
               out_valid, pixel1, pixel2, weight1, weight2, bias, out_last);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || pair_idx !== '0) begin
      errors++;
      $display("FAIL single_pair_after act=%b/%0d exp=0/0", out_valid, pair_idx);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_pixel(20'd30, 1'b0);
    send_pixel(20'd31, 1'b0);
    in_pixel = 20'd11;
    in_valid = 1'b1;
    in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          {pixel1, pixel2, weight1, weight2} !== {20'd30, 20'd31, 20'd3, 20'd5}) begin
        errors++;
        $display("FAIL backpressure cyc=%0d act=%b%b %0d %0d %0d %0d exp=01 30 31 3 5",
                 i, in_ready, out_valid, pixel1, pixel2, weight1, weight2);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready act=%b exp=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || pixel1 !== 20'd11) begin
      errors++;
      $display("FAIL release_accept act=%b/%0d exp=0/11", out_valid, pixel1);
    end
    @(posedge clk);
    #1;
    send_pixel(20'd12, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_index_wrap();
    int start;
    for (int i = 0; i < NP; i++) write_w(AW'(i), DW'(i), DW'(i + 8));
    out_ready = 1'b1;
    start = n_xfers;
    for (int i = 0; i < 2 * NP; i++) send_pixel(DW'(100 + i), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (n_xfers - start !== NP || pair_idx !== '0) begin
      errors++;
      $display("FAIL index_wrap act=%0d/%0d exp=%0d/0", n_xfers - start, pair_idx, NP);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_odd_frame();
    out_ready = 1'b0;
    send_pixel(20'd9, 1'b1);
`ifdef NEURON_FEEDER_ZERO_PAD_EN
    @(negedge clk);
    checks++;
    if ({out_valid, pixel1, pixel2, out_last} !== {1'b1, 20'd9, 20'd0, 1'b1}) begin
      errors++;
      $display("FAIL odd_pad act=%b %0d %0d %b exp=1 9 0 1", out_valid, pixel1, pixel2, out_last);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_pixel(20'd6, 1'b1);
`else
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL odd_wait act=%b exp=0", out_valid);
      end
    end
    @(posedge clk);
    #1;
    send_pixel(20'd6, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_valid, pixel1, pixel2, out_last} !== {1'b1, 20'd9, 20'd6, 1'b1}) begin
      errors++;
      $display("FAIL odd_pair act=%b %0d %0d %b exp=1 9 6 1", out_valid, pixel1, pixel2, out_last);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_write_hazard();
    out_ready = 1'b0;
    send_pixel(20'd21, 1'b0);
    send_pixel(20'd22, 1'b1);
    write_w(3'd0, 20'd1, 20'd1);
    @(negedge clk);
    checks++;
    if ({out_valid, weight1, weight2, pair_idx} !== {1'b1, 20'd0, 20'd8, 3'd0}) begin
      errors++;
      $display("FAIL hazard_held act=%b %0d %0d %0d exp=1 0 8 0", out_valid, weight1, weight2, pair_idx);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_pixel(20'd23, 1'b0);
    send_pixel(20'd24, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_valid, weight1, weight2, pair_idx} !== {1'b1, 20'd1, 20'd1, 3'd0}) begin
      errors++;
      $display("FAIL hazard_new act=%b %0d %0d %0d exp=1 1 1 0", out_valid, weight1, weight2, pair_idx);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_pixel = DW'($urandom);
      in_last = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      wr_en = ($urandom_range(0, 9) == 0);
      wr_addr = AW'($urandom_range(0, NP - 1));
      wr_weight1 = DW'($urandom);
      wr_weight2 = DW'($urandom);
      bias_wr_en = ($urandom_range(0, 15) == 0);
      bias_wr_data = DW'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_last = 1'b0; wr_en = 1'b0; bias_wr_en = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain act=%0d/%b exp=0/0", exp_q.size(), out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_pair();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    write_w(3'd0, 20'd44, 20'd55);
    send_pixel(20'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, pair_idx} !== {1'b0, 1'b1, 3'd0} ||
        {pixel1, pixel2, weight1, weight2, bias} !== '0) begin
      errors++;
      $display("FAIL reset_mid act=%b%b %0d %h exp=01 0 0", out_valid, in_ready, pair_idx,
               {pixel1, pixel2, weight1, weight2, bias});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pixel(20'd7, 1'b0);
    send_pixel(20'd8, 1'b1);
    @(negedge clk);
    checks++;
    if ({out_valid, pixel1, pixel2, weight1, weight2} !== {1'b1, 20'd7, 20'd8, 20'd0, 20'd0}) begin
      errors++;
      $display("FAIL reset_restart act=%b %0d %0d %0d %0d exp=1 7 8 0 0",
               out_valid, pixel1, pixel2, weight1, weight2);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_backpressure();
    test_index_wrap();
    test_odd_frame();
    test_write_hazard();
    test_random();
    test_reset_mid_pair();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue act=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
